// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: valid/ready requests, fixed-latency responses, post-reset clear.
// Optional feature: define MEM_PARITY_EN for per-byte even parity storage and checking.
module sp_ram_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                par_inject,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_perr,
    output logic                init_busy
);
    localparam int unsigned NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_M1 = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc;
    logic              in_range;
    logic              clearing;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;
    logic              old_perr;

    assign acc      = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < DEPTH_X;
    assign clearing = !rst && (state_q == StClear);
    assign old_word = in_range ? mem_q[req_addr] : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == DEPTH_M1) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        new_word = old_word;
        for (int b = 0; b < NB; b++) begin
            if (req_be[b]) new_word[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem_q[ptr_q] <= '0;
        end else if (acc && req_we && in_range) begin
            mem_q[req_addr] <= new_word;
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] old_par;
    logic [NB-1:0] new_par;

    // Bytes not enabled keep their stored parity, so an injected error survives partial writes.
    always_comb begin
        old_par  = in_range ? par_q[req_addr] : '0;
        new_par  = old_par;
        old_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (in_range && (old_par[b] != ^old_word[8*b +: 8])) old_perr = 1'b1;
            if (req_be[b]) new_par[b] = (^req_wdata[8*b +: 8]) ^ par_inject;
        end
    end

    always_ff @(posedge clk) begin
        if (clearing) begin
            par_q[ptr_q] <= '0;
        end else if (acc && req_we && in_range) begin
            par_q[req_addr] <= new_par;
        end
    end
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign old_perr          = 1'b0;
`endif

    logic              s1_valid_q, s1_err_q, s1_perr_q;
    logic [DATA_W-1:0] s1_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_rdata_q <= '0;
            s1_err_q   <= 1'b0;
            s1_perr_q  <= 1'b0;
        end else begin
            s1_valid_q <= acc;
            s1_rdata_q <= acc ? old_word : '0;
            s1_err_q   <= acc && !in_range;
            s1_perr_q  <= acc && old_perr;
        end
    end

    logic              out_valid, out_err, out_perr;
    logic [DATA_W-1:0] out_rdata;

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid_q, s2_err_q, s2_perr_q;
        logic [DATA_W-1:0] s2_rdata_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_rdata_q <= '0;
                s2_err_q   <= 1'b0;
                s2_perr_q  <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_rdata_q <= s1_rdata_q;
                s2_err_q   <= s1_err_q;
                s2_perr_q  <= s1_perr_q;
            end
        end

        assign out_valid = s2_valid_q;
        assign out_rdata = s2_rdata_q;
        assign out_err   = s2_err_q;
        assign out_perr  = s2_perr_q;
    end else begin : g_lat1
        assign out_valid = s1_valid_q;
        assign out_rdata = s1_rdata_q;
        assign out_err   = s1_err_q;
        assign out_perr  = s1_perr_q;
    end

    // Reset values apply combinationally in every cycle that rst is high.
    assign req_ready = !rst && (state_q == StReady);
    assign init_busy = rst || (state_q == StClear);
    assign rsp_valid = !rst && out_valid;
    assign rsp_rdata = rst ? '0 : out_rdata;
    assign rsp_err   = !rst && out_err;
    assign rsp_perr  = !rst && out_perr;

endmodule
